ret_sbc_mc: RTL and testbench

Multi-channel, parametrised stochastic-to-binary converter with progressive precision and early termination. It accepts NCH parallel stochastic bitstreams sharing one sample strobe and counts ones per channel. It emits WIDTH-bit binary estimates after a programmed stream length of 2^len_log2 samples. In progressive mode it can stop early, on request, at the next power-of-two sample boundary. It sits at the output of the stochastic datapath and feeds binary consumers through a valid/ready handshake.

---
 rtl/ret_sbc_mc.sv | 111 +++++++++++
 tb/tb_ret_sbc_mc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ret_sbc_mc.sv
// rtl/ret_sbc_mc.sv - multi-channel stochastic-to-binary converter
// Progressive power-of-two estimates with optional early termination.
module ret_sbc_mc #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [LW-1:0]        len_log2,
    input  logic                 in_valid,
    input  logic [NCH-1:0]       pz,
    input  logic                 term_req,
    output logic                 busy,
    output logic                 prog,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] Bz,
    output logic [LW-1:0]        n_log2
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                     state, state_n;
    logic [WIDTH:0]             cnt, cnt_n, tgt;
    logic [NCH-1:0][WIDTH:0]    ones, ones_n;
    logic                       term_pend, mode_r;
    logic [LW-1:0]              len_r, len_clamp, k, shamt;
    logic                       accept, is_pow2, boundary, finish, upd, prog_n;
    logic [NCH*WIDTH-1:0]       est;

    assign len_clamp = (len_log2 > LW'(WIDTH)) ? LW'(WIDTH) : len_log2;
    assign accept    = (state == RUN) && in_valid;
    assign cnt_n     = cnt + (WIDTH+1)'(1);
    assign tgt       = (WIDTH+1)'(1) << len_r;
    assign is_pow2   = ((cnt_n & (cnt_n - (WIDTH+1)'(1))) == '0);
    assign boundary  = accept && is_pow2;
    assign finish    = accept && ((cnt_n == tgt) ||
                                  (mode_r && is_pow2 && (term_pend || term_req)));
    assign upd       = finish || (boundary && mode_r);
    assign prog_n    = boundary && mode_r && !finish;
    assign shamt     = LW'(WIDTH) - k;

    // Estimate is only consumed when cnt_n is a power of two, so k is its sole set bit.
    always_comb begin
        k      = '0;
        ones_n = '0;
        est    = '0;
        for (int i = 0; i <= WIDTH; i++)
            if (cnt_n[i]) k = LW'(i);
        for (int c = 0; c < NCH; c++) begin
            ones_n[c] = ones[c] + (WIDTH+1)'(pz[c]);
            est[c*WIDTH +: WIDTH] = (ones_n[c] == cnt_n) ? {WIDTH{1'b1}}
                                                         : WIDTH'(ones_n[c] << shamt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start)     state_n = RUN;
            RUN:     if (finish)    state_n = HOLD;
            HOLD:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            ones      <= '0;
            term_pend <= 1'b0;
            mode_r    <= 1'b0;
            len_r     <= '0;
            prog      <= 1'b0;
            Bz        <= '0;
            n_log2    <= '0;
        end else begin
            prog <= prog_n;
            if (state == IDLE && start) begin
                cnt       <= '0;
                ones      <= '0;
                term_pend <= 1'b0;
                mode_r    <= mode;
                len_r     <= len_clamp;
            end
            if (state == RUN) begin
                if (mode_r && term_req) term_pend <= 1'b1;
                if (accept) begin
                    cnt  <= cnt_n;
                    ones <= ones_n;
                end
            end
            if (upd) begin
                Bz     <= est;
                n_log2 <= k;
            end
        end
    end

endmodule

// File: tb/tb_ret_sbc_mc.sv
// tb/tb_ret_sbc_mc.sv - directed bench for ret_sbc_mc
module tb_ret_sbc_mc;

    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int LW    = 4;

    logic                 clk = 1'b0;
    logic                 rst, start, mode, in_valid, term_req, out_ready;
    logic [LW-1:0]        len_log2;
    logic [NCH-1:0]       pz;
    logic                 busy, prog, out_valid;
    logic [NCH*WIDTH-1:0] Bz;
    logic [LW-1:0]        n_log2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ret_sbc_mc #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len_log2(len_log2),
        .in_valid(in_valid), .pz(pz), .term_req(term_req), .busy(busy),
        .prog(prog), .out_valid(out_valid), .out_ready(out_ready), .Bz(Bz),
        .n_log2(n_log2)
    );

    typedef struct {
        logic                 mode;
        logic [LW-1:0]        len;
        int                   term_at;
        logic [31:0][NCH-1:0] seq;
        int                   exp_cnt;
        int                   exp_prog;
        logic [NCH*WIDTH-1:0] exp_bz;
        logic [LW-1:0]        exp_n;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int s  = 0;
        int pc = 0;
        bit done = 0;
        start = 1'b1; mode = v.mode; len_log2 = v.len;
        tick();
        start = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'd1);
        while (!done && s < 300) begin
            in_valid = 1'b1;
            pz       = (s < 32) ? v.seq[s] : '0;
            term_req = (s + 1 == v.term_at);
            tick();
            s++;
            if (prog) pc++;
            if (out_valid) done = 1;
        end
        in_valid = 1'b0; term_req = 1'b0; pz = '0;
        check({tag, " samples"}, 64'(s), 64'(v.exp_cnt));
        check({tag, " Bz"}, 64'(Bz), 64'(v.exp_bz));
        check({tag, " n_log2"}, 64'(n_log2), 64'(v.exp_n));
        check({tag, " prog_count"}, 64'(pc), 64'(v.exp_prog));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, " busy_drop"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [7:0] p;
        logic [3:0] q;
        logic [NCH*WIDTH-1:0] exp_bz;
        int ones [NCH];
        int acc, s, exp_k, cyc;
        bit done;

        p = 8'b1011_0111;
        q = 4'b1101;
        for (int i = 0; i < 7; i++) vecs[i].seq = '0;
        for (int s2 = 0; s2 < 8; s2++) begin
            vecs[0].seq[s2] = {(s2 == 0), (s2 % 2 == 0), 1'b0, 1'b1};
            vecs[1].seq[s2] = {3'b000, p[s2]};
            vecs[3].seq[s2] = {3'b000, p[s2]};
        end
        for (int s2 = 0; s2 < 4; s2++) begin
            vecs[2].seq[s2] = {3'b000, q[s2]};
            vecs[4].seq[s2] = {3'b000, q[s2]};
        end
        vecs[5].seq[0] = 4'b0101;
        vecs[6].seq[0] = 4'b0011; vecs[6].seq[1] = 4'b0110;
        vecs[6].seq[2] = 4'b1010; vecs[6].seq[3] = 4'b0011;

        vecs[0].mode = 0; vecs[0].len = 3; vecs[0].term_at = 0; vecs[0].exp_cnt = 8;
        vecs[0].exp_prog = 0; vecs[0].exp_bz = {8'd32, 8'd128, 8'd0, 8'd255}; vecs[0].exp_n = 3;
        vecs[1].mode = 1; vecs[1].len = 5; vecs[1].term_at = 5; vecs[1].exp_cnt = 8;
        vecs[1].exp_prog = 3; vecs[1].exp_bz = {24'd0, 8'd192}; vecs[1].exp_n = 3;
        vecs[2].mode = 1; vecs[2].len = 5; vecs[2].term_at = 4; vecs[2].exp_cnt = 4;
        vecs[2].exp_prog = 2; vecs[2].exp_bz = {24'd0, 8'd192}; vecs[2].exp_n = 2;
        vecs[3].mode = 0; vecs[3].len = 5; vecs[3].term_at = 5; vecs[3].exp_cnt = 32;
        vecs[3].exp_prog = 0; vecs[3].exp_bz = {24'd0, 8'd48}; vecs[3].exp_n = 5;
        vecs[4].mode = 0; vecs[4].len = 5; vecs[4].term_at = 4; vecs[4].exp_cnt = 32;
        vecs[4].exp_prog = 0; vecs[4].exp_bz = {24'd0, 8'd24}; vecs[4].exp_n = 5;
        vecs[5].mode = 0; vecs[5].len = 0; vecs[5].term_at = 0; vecs[5].exp_cnt = 1;
        vecs[5].exp_prog = 0; vecs[5].exp_bz = {8'd0, 8'd255, 8'd0, 8'd255}; vecs[5].exp_n = 0;
        vecs[6].mode = 1; vecs[6].len = 2; vecs[6].term_at = 0; vecs[6].exp_cnt = 4;
        vecs[6].exp_prog = 2; vecs[6].exp_bz = {8'd64, 8'd64, 8'd255, 8'd128}; vecs[6].exp_n = 2;

        rst = 1'b1; start = 1'b0; mode = 1'b0; len_log2 = '0; in_valid = 1'b0;
        pz = '0; term_req = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset prog", 64'(prog), 64'd0);
        check("reset Bz", 64'(Bz), 64'd0);
        check("reset n_log2", 64'(n_log2), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Progressive full-length run: one prog per power of two below 256.
        start = 1'b1; mode = 1'b1; len_log2 = 4'd8;
        tick();
        start = 1'b0;
        s = 0; exp_k = 0; done = 0;
        while (!done && s < 300) begin
            in_valid = 1'b1; pz = 4'b0001;
            tick();
            s++;
            if (prog) begin
                check("prog sample", 64'(s), 64'(1 << exp_k));
                check("prog n_log2", 64'(n_log2), 64'(exp_k));
                check("prog Bz0", 64'(Bz[7:0]), 64'd255);
                exp_k++;
            end
            if (out_valid) done = 1;
        end
        in_valid = 1'b0;
        check("prog count", 64'(exp_k), 64'd8);
        check("prog final samples", 64'(s), 64'd256);
        check("prog final n_log2", 64'(n_log2), 64'd8);
        check("prog final Bz0", 64'(Bz[7:0]), 64'd255);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Random gaps, then backpressure with start/in_valid noise during HOLD.
        for (int c = 0; c < NCH; c++) ones[c] = 0;
        start = 1'b1; mode = 1'b0; len_log2 = 4'd3;
        tick();
        start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 8 && cyc < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            pz = 4'($urandom);
            if (in_valid) begin
                acc++;
                for (int c = 0; c < NCH; c++) ones[c] += int'(pz[c]);
            end
            tick();
            cyc++;
            check("gap out_valid", 64'(out_valid), 64'(acc == 8));
        end
        for (int c = 0; c < NCH; c++)
            exp_bz[c*WIDTH +: WIDTH] = (ones[c] == 8) ? 8'd255 : 8'(ones[c] << 5);
        check("gap Bz", 64'(Bz), 64'(exp_bz));
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; in_valid = 1'b1; pz = 4'($urandom);
            tick();
            check("hold out_valid", 64'(out_valid), 64'd1);
            check("hold Bz", 64'(Bz), 64'(exp_bz));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check("handshake busy", 64'(busy), 64'd0);
        check("handshake out_valid", 64'(out_valid), 64'd0);
        tick();
        start = 1'b0;
        check("restart busy", 64'(busy), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;

        // len_log2 above WIDTH clamps to WIDTH.
        start = 1'b1; mode = 1'b0; len_log2 = 4'd15;
        tick();
        start = 1'b0;
        s = 0; done = 0;
        while (!done && s < 300) begin
            in_valid = 1'b1; pz = 4'b1111;
            tick();
            s++;
            if (out_valid) done = 1;
        end
        in_valid = 1'b0;
        check("clamp samples", 64'(s), 64'd256);
        check("clamp Bz", 64'(Bz), 64'hffff_ffff);
        check("clamp n_log2", 64'(n_log2), 64'd8);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Reset mid-RUN after 37 samples.
        start = 1'b1; mode = 1'b1; len_log2 = 4'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 37; i++) begin
            in_valid = 1'b1; pz = 4'b1010;
            tick();
            check("midrun out_valid", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort prog", 64'(prog), 64'd0);
        check("abort Bz", 64'(Bz), 64'd0);
        check("abort n_log2", 64'(n_log2), 64'd0);
        run_vec(vecs[0], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
